// File: rtl/midi_rx_assembler.sv
// MIDI serial receiver with note-message assembler (status, note, velocity).
// Define MIDI_RUNNING_STATUS_EN to keep the status byte after each emitted message.
module midi_rx_assembler #(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 31250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        midi_rx,
  output logic [23:0] midi,
  output logic        midi_valid,
  output logic        frame_err
);

  localparam int unsigned ClksPerBit = CLK_HZ / BAUD;
  localparam int unsigned HalfBit    = ClksPerBit / 2;
  localparam int unsigned CntW       = $clog2(ClksPerBit + 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [1:0]      sync_q;
  logic            rx_s, rx_prev_q;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_done, stop_bad;

  logic [7:0]  status_q, status_d;
  logic [7:0]  note_q, note_d;
  logic        have_note_q, have_note_d;
  logic [23:0] midi_q, midi_d;
  logic        valid_q, valid_d;
  logic        frame_err_q;

  assign rx_s = sync_q[1];

  // Synchronizer and edge-detect history reset to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], midi_rx};
      rx_prev_q <= rx_s;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rx_prev_q && !rx_s) begin
          state_d = StStart;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      StStart: begin
        if (cnt_q == CntW'(HalfBit - 1)) begin
          cnt_d   = '0;
          state_d = rx_s ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (cnt_q == CntW'(ClksPerBit - 1)) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = StStop;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (cnt_q == CntW'(ClksPerBit - 1)) begin
          cnt_d     = '0;
          state_d   = StIdle;
          byte_done = rx_s;
          stop_bad  = !rx_s;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Message assembly; status_q[7] doubles as the "status present" flag.
  always_comb begin
    status_d    = status_q;
    note_d      = note_q;
    have_note_d = have_note_q;
    midi_d      = midi_q;
    valid_d     = 1'b0;
    if (byte_done && (shift_q < 8'hF8)) begin
      if (shift_q[7:5] == 3'b100) begin
        status_d    = shift_q;
        have_note_d = 1'b0;
      end else if (shift_q[7]) begin
        status_d    = '0;
        have_note_d = 1'b0;
      end else if (status_q[7]) begin
        if (!have_note_q) begin
          note_d      = shift_q;
          have_note_d = 1'b1;
        end else begin
          midi_d      = {status_q, note_q, shift_q};
          valid_d     = 1'b1;
          have_note_d = 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
          status_d    = status_q;
`else
          status_d    = '0;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      status_q    <= '0;
      note_q      <= '0;
      have_note_q <= 1'b0;
      midi_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      status_q    <= status_d;
      note_q      <= note_d;
      have_note_q <= have_note_d;
      midi_q      <= midi_d;
      valid_q     <= valid_d;
      frame_err_q <= stop_bad;
    end
  end

  assign midi       = midi_q;
  assign midi_valid = valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_midi_rx_assembler.sv
// Scoreboard bench for midi_rx_assembler: directed MIDI byte streams, queued expected messages.
module tb_midi_rx_assembler;

  localparam int unsigned ClkHz = 7500000;
  localparam int unsigned Baud  = 31250;
  localparam int unsigned Cpb   = 240;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        midi_rx = 1'b1;
  logic [23:0] midi;
  logic        midi_valid;
  logic        frame_err;

  logic [23:0] exp_q[$];
  logic [23:0] last_exp = '0;
  int n_vec = 0;
  int n_err = 0;
  int fe_seen = 0;
  int fe_exp = 0;

  always #5 clk = ~clk;

  midi_rx_assembler #(
    .CLK_HZ(ClkHz),
    .BAUD  (Baud)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .midi_rx   (midi_rx),
    .midi      (midi),
    .midi_valid(midi_valid),
    .frame_err (frame_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every valid pulse, counts frame_err cycles.
  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_seen++;
    if (midi_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: got midi %0h, expected no pulse", midi);
      end else begin
        check("midi", {8'h00, midi}, {8'h00, exp_q.pop_front()});
      end
    end
  end

  task automatic bit_time(input logic v);
    midi_rx = v;
    repeat (Cpb) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop);
    bit_time(1'b1);
  endtask

  task automatic expect_msg(input logic [23:0] m);
    exp_q.push_back(m);
    last_exp = m;
  endtask

  task automatic end_check(input string name);
    repeat (2 * Cpb) @(posedge clk);
    @(negedge clk);
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_frame_err"}, fe_seen, fe_exp);
    check({name, "_hold"}, {8'h00, midi}, {8'h00, last_exp});
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_midi", {8'h00, midi}, 32'h0);
    check("rst_valid", {31'h0, midi_valid}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    rst = 1'b0;
    repeat (4) @(posedge clk);

    // Basic note-on
    expect_msg(24'h904564);
    send_byte(8'h90, 1'b1); send_byte(8'h45, 1'b1); send_byte(8'h64, 1'b1);
    end_check("note_on");

    // Running status only when enabled
    expect_msg(24'h903C40);
`ifdef MIDI_RUNNING_STATUS_EN
    expect_msg(24'h903E40);
`endif
    send_byte(8'h90, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'h40, 1'b1);
    send_byte(8'h3E, 1'b1); send_byte(8'h40, 1'b1);
    end_check("running");

    // Realtime byte between note and velocity is transparent
    expect_msg(24'h803C00);
    send_byte(8'h80, 1'b1); send_byte(8'h3C, 1'b1); send_byte(8'hF8, 1'b1);
    send_byte(8'h00, 1'b1);
    end_check("realtime");

    // Bad stop bit on a status byte, then a good message
    fe_exp++;
    send_byte(8'h90, 1'b0);
    expect_msg(24'h90407F);
    send_byte(8'h90, 1'b1); send_byte(8'h40, 1'b1); send_byte(8'h7F, 1'b1);
    end_check("frame_err");

    // Frame error between note and velocity keeps status and note
    fe_exp++;
    expect_msg(24'h953344);
    send_byte(8'h95, 1'b1); send_byte(8'h33, 1'b1); send_byte(8'h12, 1'b0);
    send_byte(8'h44, 1'b1);
    end_check("fe_keep");

    // Non-note status clears status; its data bytes are ignored
    send_byte(8'hB0, 1'b1); send_byte(8'h07, 1'b1); send_byte(8'h10, 1'b1);
    end_check("cc_ignored");

    // Short low glitch on the idle line
    midi_rx = 1'b0;
    repeat (100) @(posedge clk);
    midi_rx = 1'b1;
    end_check("glitch");
    expect_msg(24'h901122);
    send_byte(8'h90, 1'b1); send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    end_check("after_glitch");

    // Reset in the middle of the velocity byte
    send_byte(8'h90, 1'b1); send_byte(8'h45, 1'b1);
    bit_time(1'b0);
    bit_time(1'b0); bit_time(1'b0); bit_time(1'b1); bit_time(1'b0);
    rst = 1'b1;
    midi_rx = 1'b1;
    @(negedge clk);
    check("midrst_midi", {8'h00, midi}, 32'h0);
    check("midrst_valid", {31'h0, midi_valid}, 32'h0);
    check("midrst_frame_err", {31'h0, frame_err}, 32'h0);
    repeat (10) @(posedge clk);
    rst = 1'b0;
    last_exp = '0;
    send_byte(8'h45, 1'b1); send_byte(8'h64, 1'b1);
    end_check("midrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
